// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial magnitude comparator: FSM state encoding and the
// running comparison decision.
package serial_cmp_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE  = 2'd0;
  localparam state_t SHIFT = 2'd1;
  localparam state_t DONE  = 2'd2;

  typedef enum logic [1:0] {
    CMP_EQ = 2'b00,
    CMP_GT = 2'b01,
    CMP_LT = 2'b10
  } decision_t;

endpackage

// File: rtl/cmp_bit_step.sv
// One bit-pair step of a serial magnitude compare: folds a_bit/b_bit into the running
// decision for either stream order.
module cmp_bit_step
  import serial_cmp_pkg::*;
(
  input  decision_t decision,
  input  logic      a_bit,
  input  logic      b_bit,
  input  logic      msb_first,
  output decision_t next_decision_c
);

  // MSB-first locks on the first difference; LSB-first lets later (more significant) bits override.
  always_comb begin
    next_decision_c = decision;
    if (a_bit != b_bit) begin
      if (!msb_first || (decision == CMP_EQ)) begin
        next_decision_c = a_bit ? CMP_GT : CMP_LT;
      end
    end
  end

endmodule

// File: rtl/serial_mag_comparator.sv
// Bit-serial magnitude comparator: accepts WIDTH bit pairs and reports registered
// one-hot GT/EQ/LT flags with a one-cycle done pulse.
module serial_mag_comparator
  import serial_cmp_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic bit_valid,
  input  logic a_bit,
  input  logic b_bit,
  output logic busy,
  output logic done,
  output logic a_gt_b,
  output logic a_eq_b,
  output logic a_lt_b
);

  localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t        state, state_nxt;
  logic [CW-1:0] count, count_nxt;
  decision_t     decision, decision_nxt;
  decision_t     step_c;
  logic          busy_nxt, done_nxt;
  logic          gt_nxt, eq_nxt, lt_nxt;

  cmp_bit_step u_step (
    .decision        (decision),
    .a_bit           (a_bit),
    .b_bit           (b_bit),
    .msb_first       (MSB_FIRST),
    .next_decision_c (step_c)
  );

  // Next-state, counter, decision and registered-output logic.
  always_comb begin
    state_nxt    = state;
    count_nxt    = count;
    decision_nxt = decision;
    done_nxt     = 1'b0;
    gt_nxt       = a_gt_b;
    eq_nxt       = a_eq_b;
    lt_nxt       = a_lt_b;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt    = SHIFT;
          count_nxt    = '0;
          decision_nxt = CMP_EQ;
        end
      end
      SHIFT: begin
        if (start) begin
          count_nxt    = '0;
          decision_nxt = CMP_EQ;
        end else if (bit_valid) begin
          decision_nxt = step_c;
          if (count == LAST) begin
            state_nxt = DONE;
            count_nxt = '0;
            done_nxt  = 1'b1;
            gt_nxt    = (step_c == CMP_GT);
            eq_nxt    = (step_c == CMP_EQ);
            lt_nxt    = (step_c == CMP_LT);
          end else begin
            count_nxt = count + CW'(1);
          end
        end
      end
      DONE: begin
        state_nxt = IDLE;
        if (start) begin
          state_nxt    = SHIFT;
          count_nxt    = '0;
          decision_nxt = CMP_EQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state_nxt == SHIFT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      count    <= '0;
      decision <= CMP_EQ;
      busy     <= 1'b0;
      done     <= 1'b0;
      a_gt_b   <= 1'b0;
      a_eq_b   <= 1'b0;
      a_lt_b   <= 1'b0;
    end else begin
      state    <= state_nxt;
      count    <= count_nxt;
      decision <= decision_nxt;
      busy     <= busy_nxt;
      done     <= done_nxt;
      a_gt_b   <= gt_nxt;
      a_eq_b   <= eq_nxt;
      a_lt_b   <= lt_nxt;
    end
  end

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Scoreboard bench for serial_mag_comparator: four instances cover WIDTH 8/2 with both
// bit orders; expected flags are queued at issue and checked when done pulses.
module tb_serial_mag_comparator;

  typedef struct {
    int         inst;
    logic [2:0] flags;  // {gt, eq, lt}
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] start, bit_valid, a_bit, b_bit;
  logic [3:0] busy, done, gt, eq, lt;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // inst 0: W8 MSB-first, 1: W8 LSB-first, 2: W2 MSB-first, 3: W2 LSB-first
  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_mag_comparator #(
      .WIDTH     ((g < 2) ? 8 : 2),
      .MSB_FIRST ((g % 2) == 0)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start[g]),
      .bit_valid (bit_valid[g]),
      .a_bit     (a_bit[g]),
      .b_bit     (b_bit[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .a_gt_b    (gt[g]),
      .a_eq_b    (eq[g]),
      .a_lt_b    (lt[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [2:0] model(input logic [7:0] a, input logic [7:0] b);
    return {a > b, a == b, a < b};
  endfunction

  function automatic logic [2:0] flags_of(input int k);
    return {gt[k], eq[k], lt[k]};
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 4; i++) begin
        if (done[i]) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_done", 32'(i), 32'hDEAD);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            chk("done_inst", 32'(i), 32'(e.inst));
            chk("result_flags", 32'(flags_of(i)), 32'(e.flags));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse(input int k);
    start[k] = 1'b1;
    bit_valid[k] = 1'b1;  // must be ignored alongside start
    a_bit[k] = 1'b1;
    b_bit[k] = 1'b0;
    tick();
    start[k] = 1'b0;
    bit_valid[k] = 1'b0;
  endtask

  task automatic beat(input int k, input logic a, input logic b);
    bit_valid[k] = 1'b1;
    a_bit[k] = a;
    b_bit[k] = b;
    tick();
    bit_valid[k] = 1'b0;
    a_bit[k] = 1'bx;
    b_bit[k] = 1'bx;
  endtask

  task automatic send(input int k, input int w, input bit msb, input logic [7:0] a,
                      input logic [7:0] b, input bit gaps);
    for (int i = 0; i < w; i++) begin
      int idx;
      idx = msb ? (w - 1 - i) : i;
      if (gaps) repeat (i % 4) tick();
      beat(k, a[idx], b[idx]);
    end
  endtask

  task automatic expect_result(input int k, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    e.inst = k;
    e.flags = model(a, b);
    exp_q.push_back(e);
  endtask

  task automatic run(input int k, input int w, input bit msb, input logic [7:0] a,
                     input logic [7:0] b, input bit gaps);
    expect_result(k, a, b);
    start_pulse(k);
    send(k, w, msb, a, b, gaps);
  endtask

  initial begin
    logic [7:0] a_hex, b_hex;
    start = '0; bit_valid = '0; a_bit = '0; b_bit = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #2;
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    chk("reset_flags", 32'({gt, eq, lt}), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // W8 MSB-first, continuous beats: 0xA5 vs 0x5A, latency and busy window
    a_hex = 8'hA5; b_hex = 8'h5A;
    expect_result(0, a_hex, b_hex);
    start_pulse(0);
    chk("busy_after_start", 32'(busy[0]), 32'h1);
    for (int i = 0; i < 8; i++) begin
      beat(0, a_hex[7-i], b_hex[7-i]);
      if (i == 6) begin
        chk("busy_before_last", 32'(busy[0]), 32'h1);
        chk("done_early", 32'(done[0]), 32'h0);
      end
    end
    chk("done_latency", 32'(done[0]), 32'h1);
    chk("busy_end", 32'(busy[0]), 32'h0);
    tick();
    chk("done_one_cycle", 32'(done[0]), 32'h0);

    // W8 MSB-first, equal operands with bit_valid gaps
    run(0, 8, 1'b1, 8'h3C, 8'h3C, 1'b1);
    repeat (2) tick();

    // W8 LSB-first: last differing bit in stream order decides
    run(1, 8, 1'b0, 8'h01, 8'h80, 1'b0);
    repeat (2) tick();
    run(1, 8, 1'b0, 8'h80, 8'h7F, 1'b0);
    repeat (2) tick();

    // Abort: partial run then restart; prior EQ flags must hold throughout
    expect_result(0, 8'h10, 8'h20);
    start_pulse(0);
    repeat (3) beat(0, 1'b1, 1'b0);
    chk("abort_flags_hold", 32'(flags_of(0)), 32'h2);
    start_pulse(0);
    chk("abort_no_done", 32'(done[0]), 32'h0);
    chk("abort_busy", 32'(busy[0]), 32'h1);
    chk("restart_flags_hold", 32'(flags_of(0)), 32'h2);
    send(0, 8, 1'b1, 8'h10, 8'h20, 1'b0);
    repeat (2) tick();

    // Asynchronous reset mid-operation
    start_pulse(0);
    repeat (5) beat(0, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", 32'(busy[0]), 32'h0);
    chk("midreset_done", 32'(done[0]), 32'h0);
    chk("midreset_flags", 32'(flags_of(0)), 32'h0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    run(0, 8, 1'b1, 8'h07, 8'h07, 1'b0);
    repeat (2) tick();

    // W2 exhaustive, both orders, back-to-back start in DONE (3-cycle period)
    for (int k = 2; k < 4; k++) begin
      for (int a = 0; a < 4; a++) begin
        for (int b = 0; b < 4; b++) begin
          run(k, 2, (k == 2), 8'(a), 8'(b), 1'b0);
          chk("w2_done_period", 32'(done[k]), 32'h1);
        end
      end
      repeat (2) tick();
    end

    repeat (4) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/serial_mag_comparator.md
Name: serial_mag_comparator

Overview:
- Bit-serial magnitude comparator. Receives two WIDTH-bit operands one bit pair per accepted beat and reports GT/EQ/LT.
- Sequential counterpart to the parallel comparator family: it sits at the receiving end of a serial link or shifter and yields the same three-flag result without a parallel operand bus.
- Supports MSB-first or LSB-first bit order.

Parameters:
- WIDTH, 8, operand width in bits; legal range is 2 or more.
- MSB_FIRST, 1, bit order: 1 means the first beat is bit WIDTH-1, 0 means the first beat is bit 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a new comparison; single-cycle strobe.
- bit_valid  input  1  a_bit/b_bit carry a valid bit pair this cycle.
- a_bit  input  1  serial bit of operand A.
- b_bit  input  1  serial bit of operand B.
- busy  output  1  a comparison is in progress (state SHIFT).
- done  output  1  one-cycle pulse: result flags were just updated.
- a_gt_b  output  1  A > B for the last completed comparison.
- a_eq_b  output  1  A == B for the last completed comparison.
- a_lt_b  output  1  A < B for the last completed comparison.

Behaviour:
- Reset (async assert, sync release): state=IDLE, count=0, decision=EQ. Outputs busy, done, a_gt_b, a_eq_b and a_lt_b are all 0, meaning no result yet.
- FSM states:
  - IDLE: start -> SHIFT, count<=0, decision<=EQ. bit_valid is ignored, including in the same cycle as start.
  - SHIFT: each cycle with bit_valid=1 accepts one pair; count<=count+1 and decision is updated. The accepted pair with count==WIDTH-1 -> DONE. bit_valid=0 holds state; gaps of any length are legal.
  - DONE: lasts exactly one cycle, then -> IDLE. If start=1 in DONE, go directly to SHIFT with count and decision cleared.
- Decision update per accepted pair, when a_bit != b_bit:
  - MSB_FIRST=1: only if decision==EQ, decision<=(a_bit ? GT : LT); otherwise hold. The first differing bit wins.
  - MSB_FIRST=0: decision<=(a_bit ? GT : LT) unconditionally. The last differing bit wins.
  - Equal bits never change the decision.
- Result flags:
  - Registered, and updated on the same edge that enters DONE, from the final decision including the last bit.
  - Exactly one flag is high after the first completion (one-hot).
  - Flags hold until the next completion; they are unaffected by start, abort, or bits of an unfinished comparison.
- Latency:
  - done=1 in the cycle immediately after the edge that samples the WIDTH-th accepted pair.
  - Minimum start-to-done is WIDTH+1 cycles: start edge, WIDTH bit edges, then done.
- busy=1 exactly while state==SHIFT.
- start in SHIFT aborts the current comparison and restarts: count<=0, decision<=EQ, no done pulse. A bit_valid in that same cycle is discarded.
- count width is $clog2(WIDTH); count never exceeds WIDTH-1.
- Reset mid-operation: immediate return to the reset values. No done pulse, and flags clear to 0.
- X-safety: a_bit/b_bit are don't-care when bit_valid=0.

Decomposition:
- Package serial_cmp_pkg:
  - state enum {IDLE, SHIFT, DONE}.
  - Decision typedef, 2 bits: CMP_EQ=2'b00, CMP_GT=2'b01, CMP_LT=2'b10.
- Sub-module cmp_bit_step (combinational): inputs decision, a_bit, b_bit, msb_first; output next decision. Reusable by a future multi-bit-per-beat variant.
- Top contains the FSM, counter and result registers.

Test Plan:
- WIDTH=8, MSB_FIRST=1: A=0xA5, B=0x5A, bit_valid continuous -> done 9 cycles after start; a_gt_b=1, a_eq_b=0, a_lt_b=0; busy high for 8 cycles.
- WIDTH=8, MSB_FIRST=1: A=B=0x3C with bit_valid gaps of 0-3 cycles between beats -> single done pulse after the 8th accepted beat; a_eq_b=1.
- WIDTH=8, MSB_FIRST=0: A=0x01, B=0x80 -> a_lt_b=1. Then A=0x80, B=0x7F -> a_gt_b=1, which confirms that the last differing bit in stream order decides.
- Abort: start, 3 beats of A=0xFF/B=0x00, start again, then full A=0x10/B=0x20 -> exactly one done; a_lt_b=1. Flags from the prior result are held during the aborted run.
- Reset: rst_n low after 5 beats -> busy, done and all flags 0 asynchronously. After release, a fresh compare A=0x07/B=0x07 -> a_eq_b=1.
- WIDTH=2, both orders: exhaustive over all 16 (A,B) pairs, using back-to-back start-in-DONE -> flags match A>B, A==B, A<B for every pair; done period is 3 cycles.
